// File: rtl/tnoc_axi_write_outstanding_limiter.sv
// Caps the number of in-flight AXI writes and keeps W data from leading its AW.
// Payloads pass straight through; only the handshakes are gated, using registered counters.
module tnoc_axi_write_outstanding_limiter #(
    parameter int ID_WIDTH        = 8,
    parameter int ADDR_WIDTH      = 64,
    parameter int DATA_WIDTH      = 64,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    // Adapter side
    input  logic                    s_awvalid,
    output logic                    s_awready,
    input  logic [ID_WIDTH-1:0]     s_awid,
    input  logic [ADDR_WIDTH-1:0]   s_awaddr,
    input  logic [7:0]              s_awlen,
    input  logic [2:0]              s_awsize,
    input  logic [1:0]              s_awburst,
    input  logic                    s_wvalid,
    output logic                    s_wready,
    input  logic [DATA_WIDTH-1:0]   s_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_wstrb,
    input  logic                    s_wlast,
    output logic                    s_bvalid,
    input  logic                    s_bready,
    output logic [ID_WIDTH-1:0]     s_bid,
    output logic [1:0]              s_bresp,
    // Slave side
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [ID_WIDTH-1:0]     m_awid,
    output logic [ADDR_WIDTH-1:0]   m_awaddr,
    output logic [7:0]              m_awlen,
    output logic [2:0]              m_awsize,
    output logic [1:0]              m_awburst,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    output logic                    m_wlast,
    input  logic                    m_bvalid,
    output logic                    m_bready,
    input  logic [ID_WIDTH-1:0]     m_bid,
    input  logic [1:0]              m_bresp,
    // Status
    output logic [CNT_WIDTH-1:0]    o_outstanding,
    output logic                    o_error
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_OUTSTANDING);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] aw_count_q, aw_count_d;
    logic [CNT_WIDTH-1:0] w_credit_q, w_credit_d;
    logic                 error_q, error_d;
    logic                 aw_allow, w_allow;
    logic                 aw_hs, w_last_hs, b_hs;

    assign aw_allow = (aw_count_q < CNT_MAX);
    assign w_allow  = (w_credit_q != '0);

    assign m_awvalid = s_awvalid & aw_allow & ~rst;
    assign s_awready = m_awready & aw_allow & ~rst;
    assign m_wvalid  = s_wvalid  & w_allow  & ~rst;
    assign s_wready  = m_wready  & w_allow  & ~rst;
    assign s_bvalid  = m_bvalid  & ~rst;
    assign m_bready  = s_bready  & ~rst;

    assign m_awid    = s_awid;
    assign m_awaddr  = s_awaddr;
    assign m_awlen   = s_awlen;
    assign m_awsize  = s_awsize;
    assign m_awburst = s_awburst;
    assign m_wdata   = s_wdata;
    assign m_wstrb   = s_wstrb;
    assign m_wlast   = s_wlast;
    assign s_bid     = m_bid;
    assign s_bresp   = m_bresp;

    assign aw_hs     = m_awvalid & m_awready;
    assign w_last_hs = m_wvalid & m_wready & m_wlast;
    assign b_hs      = m_bvalid & m_bready;

    assign o_outstanding = aw_count_q;
    assign o_error       = error_q;

    // A response with nothing outstanding is flagged and the count saturates at zero;
    // the credit clamp keeps w_credit <= aw_count even if a slave answers before the data.
    always_comb begin
        aw_count_d = aw_count_q;
        w_credit_d = w_credit_q;
        error_d    = error_q;
        if (aw_hs) begin
            aw_count_d = aw_count_d + CNT_ONE;
            w_credit_d = w_credit_d + CNT_ONE;
        end
        if (b_hs) begin
            if (aw_count_q == '0) begin
                error_d = 1'b1;
            end else begin
                aw_count_d = aw_count_d - CNT_ONE;
            end
        end
        if (w_last_hs) begin
            w_credit_d = w_credit_d - CNT_ONE;
        end
        if (w_credit_d > aw_count_d) begin
            w_credit_d = aw_count_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_count_q <= '0;
            w_credit_q <= '0;
            error_q    <= 1'b0;
        end else begin
            aw_count_q <= aw_count_d;
            w_credit_q <= w_credit_d;
            error_q    <= error_d;
        end
    end

endmodule

// File: tb/tb_tnoc_axi_write_outstanding_limiter.sv
// Self-checking bench for the write outstanding limiter: directed scenarios plus a
// randomized run checked against a queue-based model of outstanding and data-pending writes.
module tb_tnoc_axi_write_outstanding_limiter;

    localparam int ID_W   = 8;
    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int MAX    = 4;
    localparam int CW     = $clog2(MAX + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              s_awvalid, s_awready;
    logic [ID_W-1:0]   s_awid;
    logic [ADDR_W-1:0] s_awaddr;
    logic [7:0]        s_awlen;
    logic [2:0]        s_awsize;
    logic [1:0]        s_awburst;
    logic              s_wvalid, s_wready;
    logic [DATA_W-1:0] s_wdata;
    logic [DATA_W/8-1:0] s_wstrb;
    logic              s_wlast;
    logic              s_bvalid, s_bready;
    logic [ID_W-1:0]   s_bid;
    logic [1:0]        s_bresp;
    logic              m_awvalid, m_awready;
    logic [ID_W-1:0]   m_awid;
    logic [ADDR_W-1:0] m_awaddr;
    logic [7:0]        m_awlen;
    logic [2:0]        m_awsize;
    logic [1:0]        m_awburst;
    logic              m_wvalid, m_wready;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W/8-1:0] m_wstrb;
    logic              m_wlast;
    logic              m_bvalid, m_bready;
    logic [ID_W-1:0]   m_bid;
    logic [1:0]        m_bresp;
    logic [CW-1:0]     o_outstanding;
    logic              o_error;

    int checks   = 0;
    int failures = 0;

    // Reference model: writes issued and awaiting B, and writes issued and awaiting their data.
    int awQ[$];
    int wQ[$];
    bit errM;

    tnoc_axi_write_outstanding_limiter #(
        .ID_WIDTH(ID_W), .ADDR_WIDTH(ADDR_W), .DATA_WIDTH(DATA_W), .MAX_OUTSTANDING(MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid), .s_awaddr(s_awaddr),
        .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_wlast(s_wlast),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid), .m_awaddr(m_awaddr),
        .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_wlast(m_wlast),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid), .m_bresp(m_bresp),
        .o_outstanding(o_outstanding), .o_error(o_error)
    );

    always #5 clk = ~clk;

    task automatic clearModel();
        awQ.delete();
        wQ.delete();
        errM = 1'b0;
    endtask

    task automatic zeroInputs();
        s_awvalid = 0; s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0;
        s_wvalid = 0; s_wdata = '0; s_wstrb = '0; s_wlast = 0; s_bready = 0;
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_bid = '0; m_bresp = '0;
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst = 1'b1;
        zeroInputs();
        clearModel();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Drives one cycle of handshake inputs with fresh random payloads, then lets them settle.
    task automatic applyStimulus(input bit awv, input bit wv, input bit wl, input bit awr,
                                 input bit wr, input bit bv, input bit br);
        @(negedge clk);
        s_awvalid = awv; s_awid = ID_W'($urandom); s_awaddr = {$urandom, $urandom};
        s_awlen = 8'($urandom); s_awsize = 3'($urandom); s_awburst = 2'($urandom);
        s_wvalid = wv; s_wdata = {$urandom, $urandom}; s_wstrb = 8'($urandom); s_wlast = wl;
        m_awready = awr; m_wready = wr; m_bvalid = bv; s_bready = br;
        m_bid = ID_W'($urandom); m_bresp = 2'($urandom);
        #1;
    endtask

    // Advances the model across the next rising edge using the spec's acceptance rules.
    task automatic advance();
        bit awHs, wlHs, bHs;
        int id;
        awHs = s_awvalid && m_awready && (awQ.size() < MAX);
        wlHs = s_wvalid && m_wready && s_wlast && (wQ.size() != 0);
        bHs  = m_bvalid && s_bready;
        id   = int'(s_awid);
        @(posedge clk);
        if (bHs) begin
            if (awQ.size() == 0) errM = 1'b1;
            else void'(awQ.pop_front());
        end
        if (wlHs) void'(wQ.pop_front());
        if (awHs) begin
            awQ.push_back(id);
            wQ.push_back(id);
        end
        while (wQ.size() > awQ.size()) void'(wQ.pop_back());
    endtask

    function automatic logic [CW-1:0] expCount();
        return CW'(awQ.size());
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        applyStimulus(1, 1, 1, 1, 1, 1, 1);
        checks++;
        if ({m_awvalid, s_awready, m_wvalid, s_wready, s_bvalid, m_bready} !== 6'b0) begin
            failures++;
            $display("FAIL reset_handshakes got=%b exp=000000",
                     {m_awvalid, s_awready, m_wvalid, s_wready, s_bvalid, m_bready});
        end
        checks++;
        if ({o_outstanding, o_error} !== {CW'(0), 1'b0}) begin
            failures++;
            $display("FAIL reset_status got=%0d/%b exp=0/0", o_outstanding, o_error);
        end
        checks++;
        if ({m_awid, m_awaddr, m_wdata, m_wlast, s_bid, s_bresp} !==
            {s_awid, s_awaddr, s_wdata, s_wlast, m_bid, m_bresp}) begin
            failures++;
            $display("FAIL reset_payload_passthrough got=%h exp=%h",
                     {m_awid, m_awaddr, m_wdata, m_wlast, s_bid, s_bresp},
                     {s_awid, s_awaddr, s_wdata, s_wlast, m_bid, m_bresp});
        end
        applyReset();
    endtask

    task automatic test_aw_before_w();
        applyReset();
        applyStimulus(1, 1, 1, 1, 1, 0, 0);
        checks++;
        if ({m_awvalid, m_wvalid, s_wready} !== 3'b100) begin
            failures++;
            $display("FAIL aw_first_cycle aw/w/wready got=%b exp=100", {m_awvalid, m_wvalid, s_wready});
        end
        advance();
        applyStimulus(0, 1, 1, 1, 1, 0, 0);
        checks++;
        if ({m_wvalid, s_wready} !== 2'b11) begin
            failures++;
            $display("FAIL w_next_cycle got=%b exp=11", {m_wvalid, s_wready});
        end
        advance();
        applyStimulus(0, 1, 1, 1, 1, 0, 0);
        checks++;
        if ({m_wvalid, s_wready, o_outstanding} !== {2'b00, CW'(1)}) begin
            failures++;
            $display("FAIL w_credit_spent got=%b exp=%b", {m_wvalid, s_wready, o_outstanding}, {2'b00, CW'(1)});
        end
        advance();
        applyStimulus(0, 0, 0, 0, 0, 1, 1);
        advance();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (o_outstanding !== expCount() || o_outstanding !== CW'(0)) begin
            failures++;
            $display("FAIL b_retires got=%0d exp=0", o_outstanding);
        end
        advance();
    endtask

    task automatic test_max_stall();
        applyReset();
        for (int i = 0; i < MAX + 1; i++) begin
            bit expAw;
            applyStimulus(1, 0, 0, 1, 0, 0, 0);
            expAw = (awQ.size() < MAX);
            checks++;
            if ({m_awvalid, s_awready} !== {expAw, expAw}) begin
                failures++;
                $display("FAIL stall_aw%0d got=%b exp=%b", i, {m_awvalid, s_awready}, {expAw, expAw});
            end
            advance();
        end
        applyStimulus(1, 0, 0, 1, 0, 1, 1);
        checks++;
        if ({o_outstanding, m_awvalid, s_awready} !== {CW'(MAX), 2'b00}) begin
            failures++;
            $display("FAIL stall_with_b got=%b exp=%b", {o_outstanding, m_awvalid, s_awready}, {CW'(MAX), 2'b00});
        end
        advance();
        applyStimulus(1, 0, 0, 1, 0, 0, 0);
        checks++;
        if ({o_outstanding, m_awvalid} !== {CW'(MAX - 1), 1'b1}) begin
            failures++;
            $display("FAIL stall_release got=%b exp=%b", {o_outstanding, m_awvalid}, {CW'(MAX - 1), 1'b1});
        end
        advance();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (o_outstanding !== CW'(MAX)) begin
            failures++;
            $display("FAIL stall_refill got=%0d exp=%0d", o_outstanding, MAX);
        end
        advance();
    endtask

    task automatic test_burst();
        logic [DATA_W-1:0] sent[4];
        int beat = 0;
        applyReset();
        applyStimulus(1, 0, 0, 1, 0, 0, 0);
        s_awlen = 8'd3;
        #1;
        advance();
        for (int cyc = 0; cyc < 12 && beat < 4; cyc++) begin
            bit expRdy;
            applyStimulus(0, 1, beat == 3, 1, cyc % 2 == 0, 0, 0);
            sent[beat] = s_wdata;
            expRdy = m_wready && (wQ.size() != 0);
            checks++;
            if ({s_wready, m_wvalid, m_wdata, m_wlast} !== {expRdy, wQ.size() != 0, sent[beat], beat == 3}) begin
                failures++;
                $display("FAIL burst_beat%0d rdy/vld/data/last got=%b/%b/%h/%b exp=%b/%b/%h/%b", beat,
                         s_wready, m_wvalid, m_wdata, m_wlast, expRdy, wQ.size() != 0, sent[beat], beat == 3);
            end
            if (expRdy) beat++;
            advance();
        end
        checks++;
        if (beat != 4) begin
            failures++;
            $display("FAIL burst_timeout beats=%0d exp=4", beat);
        end
        applyStimulus(0, 1, 1, 0, 1, 0, 0);
        checks++;
        if ({s_wready, m_wvalid, o_outstanding} !== {2'b00, CW'(1)}) begin
            failures++;
            $display("FAIL burst_no_credit got=%b exp=%b", {s_wready, m_wvalid, o_outstanding}, {2'b00, CW'(1)});
        end
        advance();
    endtask

    task automatic test_error();
        applyReset();
        applyStimulus(0, 0, 0, 0, 0, 1, 1);
        checks++;
        if (s_bvalid !== 1'b1 || m_bready !== 1'b1) begin
            failures++;
            $display("FAIL error_b_passthrough got=%b exp=11", {s_bvalid, m_bready});
        end
        advance();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0);
            checks++;
            if ({o_error, o_outstanding} !== {errM, expCount()} || errM !== 1'b1) begin
                failures++;
                $display("FAIL error_sticky%0d got=%b/%0d exp=1/0", i, o_error, o_outstanding);
            end
            advance();
        end
        applyReset();
        checks++;
        if (o_error !== 1'b0) begin
            failures++;
            $display("FAIL error_cleared got=%b exp=0", o_error);
        end
    endtask

    task automatic test_async_reset();
        applyReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 0, 1, 0, 0, 0);
            advance();
        end
        applyStimulus(0, 1, 1, 0, 1, 0, 0);
        advance();
        applyStimulus(1, 1, 0, 1, 1, 1, 1);
        checks++;
        if (o_outstanding !== expCount() || expCount() !== CW'(3) || wQ.size() != 2) begin
            failures++;
            $display("FAIL async_setup got=%0d exp=3", o_outstanding);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({o_outstanding, m_awvalid, s_awready, m_wvalid, s_wready, s_bvalid, m_bready} !== {CW'(0), 6'b0}) begin
            failures++;
            $display("FAIL async_reset got=%b exp=%b",
                     {o_outstanding, m_awvalid, s_awready, m_wvalid, s_wready, s_bvalid, m_bready}, {CW'(0), 6'b0});
        end
        @(negedge clk);
        rst = 1'b0;
        zeroInputs();
        clearModel();
        applyStimulus(1, 1, 1, 1, 1, 0, 0);
        checks++;
        if ({m_awvalid, s_awready, m_wvalid, s_wready} !== 4'b1100) begin
            failures++;
            $display("FAIL async_resume got=%b exp=1100", {m_awvalid, s_awready, m_wvalid, s_wready});
        end
        advance();
    endtask

    task automatic test_random();
        applyReset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            bit legalB, expAw, expW;
            logic [5:0] expHs;
            legalB = awQ.size() > wQ.size();
            applyStimulus($urandom_range(9) < 6, $urandom_range(9) < 6, $urandom_range(1) == 1,
                          $urandom_range(9) < 7, $urandom_range(9) < 7,
                          legalB && $urandom_range(1) == 1, $urandom_range(9) < 7);
            expAw = awQ.size() < MAX;
            expW  = wQ.size() != 0;
            expHs = {s_awvalid & expAw, m_awready & expAw, s_wvalid & expW, m_wready & expW, m_bvalid, s_bready};
            checks++;
            if ({m_awvalid, s_awready, m_wvalid, s_wready, s_bvalid, m_bready} !== expHs) begin
                failures++;
                $display("FAIL random_gating cyc=%0d got=%b exp=%b", cyc,
                         {m_awvalid, s_awready, m_wvalid, s_wready, s_bvalid, m_bready}, expHs);
            end
            checks++;
            if (o_outstanding !== expCount()) begin
                failures++;
                $display("FAIL random_outstanding cyc=%0d got=%0d exp=%0d", cyc, o_outstanding, expCount());
            end
            checks++;
            if (o_error !== errM) begin
                failures++;
                $display("FAIL random_error cyc=%0d got=%b exp=%b", cyc, o_error, errM);
            end
            checks++;
            if ({m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_wdata, m_wstrb, m_wlast, s_bid, s_bresp} !==
                {s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_wdata, s_wstrb, s_wlast, m_bid, m_bresp}) begin
                failures++;
                $display("FAIL random_payload cyc=%0d got=%h exp=%h", cyc,
                         {m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_wdata, m_wstrb, m_wlast, s_bid, s_bresp},
                         {s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_wdata, s_wstrb, s_wlast, m_bid, m_bresp});
            end
            advance();
        end
    endtask

    initial begin
        rst = 1'b1;
        zeroInputs();
        clearModel();
        test_reset();
        test_aw_before_w();
        test_max_stall();
        test_burst();
        test_error();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tnoc_axi_write_outstanding_limiter.md
Name: tnoc_axi_write_outstanding_limiter

Overview:
- Sits between the NoC-side AXI master write adapter and the external AXI slave.
- Caps the number of outstanding write transactions. A transaction is outstanding from AW handshake until B handshake.
- Forbids W data from leading its AW on the slave side.
- Payload paths are zero-latency pass-through. Only valid/ready are gated, from registered counters.

Parameters:
- ID_WIDTH, 8, AXI ID width (location id + tag)
- ADDR_WIDTH, 64, AXI address width
- DATA_WIDTH, 64, AXI data width; strobe width is DATA_WIDTH/8
- MAX_OUTSTANDING, 4, maximum accepted-but-unresponded writes; must be ≥ 1
- CNT_WIDTH, $clog2(MAX_OUTSTANDING+1), counter width (derived)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- s_awvalid / s_awready  in/out  1  AW handshake, adapter side
- s_awid, s_awaddr, s_awlen, s_awsize, s_awburst  in  ID_WIDTH, ADDR_WIDTH, 8, 3, 2  AW payload, adapter side
- s_wvalid / s_wready  in/out  1  W handshake, adapter side
- s_wdata, s_wstrb, s_wlast  in  DATA_WIDTH, DATA_WIDTH/8, 1  W payload, adapter side
- s_bvalid / s_bready  out/in  1  B handshake, adapter side
- s_bid, s_bresp  out  ID_WIDTH, 2  B payload, adapter side
- m_aw*, m_w*, m_b*  mirror of s_* (directions reversed)  same widths  slave side
- o_outstanding  out  CNT_WIDTH  current aw_count
- o_error  out  1  sticky protocol error flag

Behaviour:
Reset:
- aw_count=0, w_credit=0, o_error=0.
- While rst is high, m_awvalid, m_wvalid, s_awready, s_wready, s_bvalid and m_bready are all forced to 0.
Payloads:
- m_aw*, m_w* and s_b* payloads are driven combinationally from their source. There is no storage.
aw_count (0..MAX_OUTSTANDING):
- Increments on m_awvalid&m_awready.
- Decrements on m_bvalid&m_bready.
- Both events in the same cycle: unchanged.
w_credit (0..MAX_OUTSTANDING):
- Counts AWs issued whose W burst has not yet completed.
- Increments on the AW handshake.
- Decrements on m_wvalid&m_wready&m_wlast.
- Both events in the same cycle: unchanged.
- Invariant: w_credit ≤ aw_count.
AW gating:
- aw_allow = (aw_count < MAX_OUTSTANDING).
- m_awvalid = s_awvalid & aw_allow; s_awready = m_awready & aw_allow.
- At aw_count == MAX_OUTSTANDING, AW is stalled. It is released the cycle after a B handshake.
W gating:
- w_allow = (w_credit != 0).
- m_wvalid = s_wvalid & w_allow; s_wready = m_wready & w_allow.
- An AW handshake in cycle N enables W no earlier than cycle N+1. W is never forwarded in the same cycle as its AW.
B path:
- s_bvalid = m_bvalid; m_bready = s_bready. Never gated.
Valid stability:
- Gating never deasserts an already-presented m_awvalid or m_wvalid without a handshake.
- Reason: aw_count rises only on an AW handshake, and w_credit falls only on a W-last handshake.
- Implementation must not add any other gating term.
Error handling:
- B handshake with aw_count==0 sets o_error. The counter saturates at 0.
- o_error is sticky until rst.
- Overflow cannot occur by construction.
Reset mid-operation:
- Counters clear immediately (asynchronous).
- In-flight transactions are discarded. The slave must be reset in the same domain.
- Outputs follow the reset rules above on the first cycle after rst deasserts.
Simultaneous events:
- AW, W-last and B handshakes in one cycle are all counted in that cycle.
- Example: aw_count 2, AW+B → 2; w_credit 1, AW+Wlast → 1.

Test Plan:
- Reset, then s_awvalid=1 and s_wvalid=1 in the same cycle, m_awready=m_wready=1 → AW handshake at cycle 0. m_wvalid stays 0 at cycle 0 and rises at cycle 1. w_credit: 0→1→0 after the single-beat wlast.
- MAX_OUTSTANDING=4, 5 back-to-back AWs with m_awready=1 and no B → 4 accepted, o_outstanding=4, s_awready=0. Fifth AW is held with m_awvalid=0. One B handshake → fifth AW handshakes on the next cycle, o_outstanding returns to 4.
- aw_count=4, B handshake in the same cycle as a stalled AW → AW is not accepted that cycle; count goes to 3, then back to 4 the following cycle.
- Burst awlen=3 (4 beats), m_wready toggling 1/0 → 4 beats pass in order. w_credit decrements only on the beat with wlast=1. s_wready is never 1 when w_credit=0.
- m_bvalid=1 pulsed with aw_count=0 → o_error=1 and stays 1. o_outstanding stays 0. rst clears o_error.
- rst asserted with aw_count=3, w_credit=2 → o_outstanding=0 immediately (asynchronous). All valid/ready outputs are 0 during reset. Normal operation resumes after rst deasserts.
